leaf_user_in_fifo: RTL and testbench

//  Elastic buffer between one leaf_interface output port (…interface2user_N) and the user kernel input.

---
 rtl/leaf_user_in_fifo.sv | 72 +++++++
 tb/tb_leaf_user_in_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_in_fifo.sv
// Elastic FWFT buffer between leaf_interface output and the user kernel.
// Back-pressures leaf_interface only when full; vld/ack handshake both sides.
module leaf_user_in_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int ADDR_BITS    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din_interface,
  input  logic                    vld_interface,
  output logic                    ack_to_interface,
  output logic [PAYLOAD_BITS-1:0] dout_user,
  output logic                    vld_user,
  input  logic                    ack_from_user,
  output logic [ADDR_BITS:0]      occupancy,
  output logic                    almost_full
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] ONE_C   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]      occ_q, occ_d;
  logic                    push, pop;

  // Handshake outputs depend on registered occupancy only
  assign ack_to_interface = (occ_q != DEPTH_C);
  assign vld_user         = (occ_q != '0);
  assign almost_full      = (occ_q >= AFULL_C);
  assign occupancy        = occ_q;
  assign dout_user        = mem_q[rd_ptr_q];

  assign push = vld_interface & ack_to_interface;
  assign pop  = vld_user & ack_from_user;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not reset; stale contents are hidden by occupancy
  always_ff @(posedge clk_user) begin
    if (push) mem_q[wr_ptr_q] <= din_interface;
  end

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Directed bench for leaf_user_in_fifo: reset, fill, drain, full
// concurrency, random wrap traffic and occupancy-1 push+pop.
module tb_leaf_user_in_fifo;

  logic        clk_user = 1'b0;
  logic        reset_n;
  logic [31:0] din_interface;
  logic        vld_interface;
  logic        ack_to_interface;
  logic [31:0] dout_user;
  logic        vld_user;
  logic        ack_from_user;
  logic [4:0]  occupancy;
  logic        almost_full;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;
  logic [31:0] q[$];

  always #5 clk_user = ~clk_user;

  leaf_user_in_fifo #(
    .PAYLOAD_BITS(32),
    .ADDR_BITS(4),
    .AFULL_THRESH(12)
  ) dut (
    .clk_user(clk_user),
    .reset_n(reset_n),
    .din_interface(din_interface),
    .vld_interface(vld_interface),
    .ack_to_interface(ack_to_interface),
    .dout_user(dout_user),
    .vld_user(vld_user),
    .ack_from_user(ack_from_user),
    .occupancy(occupancy),
    .almost_full(almost_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  // One clock with current inputs, checked against the queue model
  task automatic xfer(input string tag);
    bit p, o;
    logic [31:0] d;
    p = vld_interface && (q.size() < 16);
    o = ack_from_user && (q.size() > 0);
    d = din_interface;
    chk({tag, "_ack_if"}, ack_to_interface, q.size() < 16);
    chk({tag, "_vld_user"}, vld_user, q.size() > 0);
    if (q.size() > 0) chk({tag, "_dout"}, dout_user, q[0]);
    step();
    if (o) begin
      void'(q.pop_front());
      pops++;
    end
    if (p) begin
      q.push_back(d);
      pushes++;
    end
    chk({tag, "_occ"}, occupancy, q.size());
    chk({tag, "_afull"}, almost_full, q.size() >= 12);
  endtask

  initial begin
    int cyc;
    reset_n       = 1'b0;
    din_interface = '0;
    vld_interface = 1'b0;
    ack_from_user = 1'b0;
    step();
    step();
    chk("rst_ack_if", ack_to_interface, 1);
    chk("rst_vld_user", vld_user, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_afull", almost_full, 0);
    reset_n = 1'b1;
    step();

    // T1: five words in, then asynchronous reset mid-cycle
    vld_interface = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din_interface = 32'h100 + i;
      step();
    end
    vld_interface = 1'b0;
    chk("t1_occ5", occupancy, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_async_vld", vld_user, 0);
    chk("t1_async_occ", occupancy, 0);
    chk("t1_async_ack", ack_to_interface, 1);
    step();
    reset_n = 1'b1;
    din_interface = 32'hA5A5_0001;
    vld_interface = 1'b1;
    chk("t1_nobypass", vld_user, 0);
    step();
    vld_interface = 1'b0;
    chk("t1_vld", vld_user, 1);
    chk("t1_dout", dout_user, 32'hA5A5_0001);
    chk("t1_occ1", occupancy, 1);
    ack_from_user = 1'b1;
    step();
    ack_from_user = 1'b0;
    chk("t1_drained", occupancy, 0);
    q = {};

    // T2: fill with kernel stalled
    ack_from_user = 1'b0;
    vld_interface = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_interface = i;
      xfer("t2");
    end
    chk("t2_full_ack", ack_to_interface, 0);
    chk("t2_full_occ", occupancy, 16);
    din_interface = 32'h99;
    xfer("t2_17th");
    chk("t2_17th_occ", occupancy, 16);

    // T3: drain in order
    vld_interface = 1'b0;
    ack_from_user = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_vld", vld_user, 1);
      chk("t3_dout", dout_user, i);
      step();
    end
    void'(q.size());
    q = {};
    chk("t3_empty_vld", vld_user, 0);
    chk("t3_empty_occ", occupancy, 0);

    // T4: both sides active starting from full
    ack_from_user = 1'b0;
    vld_interface = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_interface = 32'h400 + i;
      xfer("t4_fill");
    end
    ack_from_user = 1'b1;
    din_interface = 32'h410;
    xfer("t4_c1");
    chk("t4_first_pop_only", occupancy, 15);
    for (int i = 1; i < 20; i++) begin
      din_interface = 32'h410 + i;
      xfer("t4_steady");
    end
    vld_interface = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      xfer("t4_drain");
      cyc++;
    end
    chk("t4_drain_done", q.size(), 0);

    // T5: random handshakes, 40 words
    pushes = 0;
    pops = 0;
    cyc = 0;
    while (pops < 40 && cyc < 2000) begin
      vld_interface = (pushes < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      din_interface = $urandom;
      ack_from_user = 1'($urandom_range(0, 1));
      xfer("t5");
      cyc++;
    end
    chk("t5_pushes", pushes, 40);
    chk("t5_pops", pops, 40);

    // T6: push and pop together at occupancy 1
    vld_interface = 1'b0;
    ack_from_user = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 40) begin
      xfer("t6_drain");
      cyc++;
    end
    ack_from_user = 1'b0;
    vld_interface = 1'b1;
    din_interface = 32'hCAFE_0001;
    xfer("t6_one");
    ack_from_user = 1'b1;
    din_interface = 32'hBEEF_0002;
    xfer("t6_both");
    chk("t6_occ", occupancy, 1);
    chk("t6_vld", vld_user, 1);
    chk("t6_dout", dout_user, 32'hBEEF_0002);
    vld_interface = 1'b0;
    ack_from_user = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
